// File: rtl/sd_crc16.sv
// ---------------------------------------------------------------------------
// sd_crc16
//
// Bit-serial CRC-16 generator/checker for one SD-card DAT line.
// Polynomial x^16 + x^12 + x^5 + 1 (0x1021), initial value 0x0000, no final
// XOR, data absorbed MSB-first. The SD data host instantiates one copy per
// DAT line. Each copy accumulates the CRC of the block being sent or
// received. The host either shifts the result out or compares it against the
// received CRC bits. As a check, clocking the received CRC bits back in
// leaves the register at zero when the block was error-free.
//
// Ports
//   sd_clk  in   1   clock, state updates on the rising edge
//   rst     in   1   asynchronous active-high clear (per-block clear)
//   bitval  in   1   serial data bit for the current cycle
//   enable  in   1   1 = absorb bitval on this edge, 0 = hold
//   crc     out  16  current CRC register, straight from the flops
// ---------------------------------------------------------------------------
module sd_crc16 (
    input  logic        sd_clk,
    input  logic        rst,
    input  logic        bitval,
    input  logic        enable,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // One LFSR step written out tap by tap. The feedback bit enters at
    // bit 0 and is folded into the taps feeding bits 5 and 12.
    function automatic logic [15:0] crc16_step(input logic [15:0] c,
                                               input logic        b);
        logic        fb;
        logic [15:0] n;
        fb        = b ^ c[15];
        n[0]      = fb;
        n[4:1]    = c[3:0];
        n[5]      = c[4] ^ fb;
        n[11:6]   = c[10:5];
        n[12]     = c[11] ^ fb;
        n[15:13]  = c[14:12];
        return n;
    endfunction

    always_comb begin
        crc_d = crc16_step(crc_q, bitval);
    end

    // The register loads only when enable is high. An unknown bitval during
    // a hold therefore never reaches the register.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else if (enable) begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: tb/tb_sd_crc16.sv
module tb_sd_crc16;

    logic        sd_clk = 1'b0;
    logic        rst;
    logic        bitval;
    logic        enable;
    logic [15:0] crc;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [15:0] model;
    logic [7:0]  msg [0:8];

    sd_crc16 dut (
        .sd_clk (sd_clk),
        .rst    (rst),
        .bitval (bitval),
        .enable (enable),
        .crc    (crc)
    );

    always #5 sd_clk = ~sd_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: shift-then-conditionally-XOR form of the CRC.
    function automatic logic [15:0] ref_step(input logic [15:0] m, input logic b);
        return {m[14:0], 1'b0} ^ (((b ^ m[15]) == 1'b1) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge and are sampled on the next rising edge.
    task automatic drive(input logic b, input logic en);
        @(negedge sd_clk);
        bitval = b;
        enable = en;
        if (en) model = ref_step(model, b);
    endtask

    // The last driven bit has been absorbed once this returns.
    task automatic settle();
        @(negedge sd_clk);
        enable = 1'b0;
        bitval = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sd_clk);
        enable = 1'b0;
        rst    = 1'b1;
        model  = 16'h0000;
        @(negedge sd_clk);
        rst    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drive(b[i], 1'b1);
    endtask

    initial begin
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst    = 1'b1;
        bitval = 1'b0;
        enable = 1'b0;
        model  = 16'h0000;
        #2;
        chk("reset_initial", crc, 16'h0000);
        @(negedge sd_clk);
        rst = 1'b0;

        // 1: asynchronous clear from a non-zero state
        send_byte(8'hA5);
        send_byte(8'h3C);
        settle();
        chk("pre_async_state", crc, model);
        #1 rst = 1'b1;
        #1 chk("async_clear", crc, 16'h0000);
        @(negedge sd_clk);
        rst   = 1'b0;
        model = 16'h0000;

        // 2: single one, then 16 zeros, then hold
        drive(1'b1, 1'b1);
        settle();
        chk("one_bit", crc, 16'h1021);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1);
        settle();
        chk("plus_16_zeros", crc, 16'h3730);
        for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 1'b0);
        settle();
        chk("hold_10", crc, 16'h3730);

        // 3: "123456789"
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(msg[i]);
        settle();
        chk("ascii_123456789", crc, 16'h31C3);

        // 4: 512 bytes of 0xFF, then 5: append the CRC
        do_reset();
        for (int i = 0; i < 512; i++) send_byte(8'hFF);
        settle();
        chk("ff_block", crc, 16'h7FA1);
        send_byte(8'h7F);
        send_byte(8'hA1);
        settle();
        chk("ff_block_residue", crc, 16'h0000);

        // 5b: a single flipped data bit must leave a non-zero residue
        foreach (msg[k]) begin
            if (k < 3) begin
                int p;
                p = (k == 0) ? 0 : ((k == 1) ? 2000 : 4095);
                do_reset();
                for (int i = 0; i < 4096; i++) drive(i != p, 1'b1);
                send_byte(8'h7F);
                send_byte(8'hA1);
                settle();
                chk($sformatf("flip_%0d_nonzero", p), {15'd0, crc != 16'h0000}, 16'h0001);
            end
        end

        // 6: random enable gaps with junk on bitval while disabled
        do_reset();
        for (int i = 0; i < 9; i++) begin
            for (int j = 7; j >= 0; j--) begin
                repeat ($urandom_range(0, 3)) drive(1'($urandom_range(0, 1)), 1'b0);
                drive(msg[i][j], 1'b1);
            end
        end
        settle();
        chk("gapped_123456789", crc, 16'h31C3);

        // Random stream against the reference, with resets mid-stream
        do_reset();
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(5, 40))
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) do_reset();
            settle();
            chk($sformatf("rand_%0d", r), crc, model);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
